adder32_slice_sequencer: RTL and testbench
==========================================

# adder32_slice_sequencer

Sequential controller that evaluates a WIDTH-bit addition one SLICE-bit partition per clock cycle, reusing a single slice datapath. Each partition runs in exact mode or in BMF rank-1 approximate mode, selected by a per-slice mask. The block sits above the partitioned adder slices and lets the approximation/accuracy trade-off be configured at run time. It presents a start/busy/done handshake to its requester.

## Interface
- WIDTH, 32, operand width; must be a multiple of SLICE.
- SLICE, 4, bits per partition; SLICE >= 2; NUM_SLICES = WIDTH/SLICE (8 by default).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request; accepted only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in to slice 0; captured on accepted start.
- approx_mask  input  NUM_SLICES  bit i=1 selects approximate mode for slice i; captured on accepted start.
- busy  output  1  high while slices are being evaluated (RUN).
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  carry out of the last slice; held with sum.
- approx_cnt  output  clog2(NUM_SLICES+1)  popcount of the captured mask; valid with sum.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 captures a, b, cin and approx_mask, clears sum, sets slice index idx=0 and carry register c=cin, and moves to RUN.
- RUN: each cycle, slice idx is evaluated on a_s = a[idx*SLICE +: SLICE], b_s and c.
  - Exact mode (mask bit 0): {c_out, s} = a_s + b_s + c, where s is SLICE bits wide.
  - Approximate mode (mask bit 1): s[SLICE-1] = a_s[SLICE-1] ^ b_s[SLICE-1] ^ c, all other bits of s are 0, and c_out = a_s[SLICE-1] & b_s[SLICE-1].
  - s is written to sum[idx*SLICE +: SLICE], c <= c_out and idx increments.
  - After slice NUM_SLICES-1 the state moves to DONE, and cout = c_out of that slice.
- DONE: done=1 for exactly one cycle.
  - start=1 in this cycle is accepted exactly as in IDLE (back-to-back operation); the next state is RUN.
  - Otherwise the next state is IDLE.
- start while in RUN is ignored. The captured operands and mask stay unchanged, and no request is queued.
- Input changes after capture have no effect on the operation in progress.
- approx_cnt is computed at capture and is stable from capture onward.
- Exact-mode arithmetic carries no information beyond the SLICE+1 bits per slice. Overflow appears only on cout.

## Timing
- Reset values: state IDLE, busy=0, done=0, sum=0, cout=0, approx_cnt=0, idx=0, c=0.
- Reset asserted at any point, including mid-RUN, aborts the operation immediately. No done pulse is produced for an aborted operation.
- Capture edge E0: busy=1 from E0 until edge E(NUM_SLICES).
- Slice i is written at edge E(i+1).
- After edge E(NUM_SLICES): busy=0 and done=1 for one cycle, and sum/cout are final.
- Latency from the capture edge to done: NUM_SLICES cycles. Throughput: one operation every NUM_SLICES+1 cycles with back-to-back starts.
- Partial sum bits are visible on sum during RUN. Consumers sample sum only when done=1.
- busy and done are never high in the same cycle.

## Test plan
- a=0x0000000F, b=0x00000001, cin=0, mask=0x00 -> done 8 cycles after capture; sum=0x00000010, cout=0, approx_cnt=0.
- Same operands with mask=0x01 -> sum=0x00000008, cout=0, approx_cnt=1.
- a=0xFFFFFFFF, b=0x00000001, mask=0x00 -> sum=0x00000000, cout=1. Check busy is high for exactly 8 cycles and done for exactly 1.
- a=b=0xFFFFFFFF, cin=0, mask=0xFF -> sum=0x88888880, cout=1, approx_cnt=8.
- Second start with different operands issued at cycle 3 of RUN -> ignored; the result matches the first operands. A start in the DONE cycle is accepted, and the second done follows 8 cycles later.
- rst_n pulsed low at cycle 4 of RUN -> busy, done, sum and cout go to 0 asynchronously, with no done pulse. A following start completes normally.

Source files
------------

// File: rtl/adder32_slice_sequencer_if.sv
// rtl/adder32_slice_sequencer_if.sv - start/busy/done request interface for the slice-sequenced adder
interface adder32_slice_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
);
  localparam int NUM_SLICES = WIDTH / SLICE;
  localparam int CNT_W      = $clog2(NUM_SLICES + 1);

  logic                  start;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic                  cin;
  logic [NUM_SLICES-1:0] approx_mask;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      sum;
  logic                  cout;
  logic [CNT_W-1:0]      approx_cnt;

  modport master (
    output start, a, b, cin, approx_mask,
    input  busy, done, sum, cout, approx_cnt
  );

  modport slave (
    input  start, a, b, cin, approx_mask,
    output busy, done, sum, cout, approx_cnt
  );
endinterface

// File: rtl/adder32_slice_sequencer.sv
// rtl/adder32_slice_sequencer.sv - WIDTH-bit adder evaluated one SLICE-bit partition per cycle,
// each partition exact or BMF rank-1 approximate under a per-slice mask
module adder32_slice_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  adder32_slice_sequencer_if.slave   bus
);
  localparam int NUM_SLICES = WIDTH / SLICE;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int CNT_W      = $clog2(NUM_SLICES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_next;
  logic [WIDTH-1:0]      a_q, b_q, sum_q;
  logic [NUM_SLICES-1:0] mask_q;
  logic [IDX_W-1:0]      idx;
  logic                  c, cout_q;
  logic [CNT_W-1:0]      cnt_q, start_cnt;

  logic                  accept, last, mode, c_out;
  logic [SLICE-1:0]      a_s, b_s, s;
  logic [SLICE:0]        exact;

  assign accept = bus.start && ((state == IDLE) || (state == DONE));
  assign last   = (idx == IDX_W'(NUM_SLICES - 1));

  always_comb begin
    start_cnt = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (bus.approx_mask[i]) start_cnt = start_cnt + CNT_W'(1);
    end
  end

  // Single shared slice datapath, fed by a mux over the captured operands
  always_comb begin
    a_s  = '0;
    b_s  = '0;
    mode = 1'b0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_s  = a_q[i*SLICE +: SLICE];
        b_s  = b_q[i*SLICE +: SLICE];
        mode = mask_q[i];
      end
    end
  end

  assign exact = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, c};

  always_comb begin
    s     = exact[SLICE-1:0];
    c_out = exact[SLICE];
    if (mode) begin
      s            = '0;
      s[SLICE-1]   = a_s[SLICE-1] ^ b_s[SLICE-1] ^ c;
      c_out        = a_s[SLICE-1] & b_s[SLICE-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mask_q <= '0;
      sum_q  <= '0;
      idx    <= '0;
      c      <= 1'b0;
      cout_q <= 1'b0;
      cnt_q  <= '0;
    end else if (accept) begin
      a_q    <= bus.a;
      b_q    <= bus.b;
      mask_q <= bus.approx_mask;
      sum_q  <= '0;
      idx    <= '0;
      c      <= bus.cin;
      cout_q <= 1'b0;
      cnt_q  <= start_cnt;
    end else if (state == RUN) begin
      for (int i = 0; i < NUM_SLICES; i++) begin
        if (idx == IDX_W'(i)) sum_q[i*SLICE +: SLICE] <= s;
      end
      c   <= c_out;
      idx <= last ? '0 : idx + IDX_W'(1);
      if (last) cout_q <= c_out;
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.sum        = sum_q;
  assign bus.cout       = cout_q;
  assign bus.approx_cnt = cnt_q;
endmodule

// File: tb/tb_adder32_slice_sequencer.sv
// tb/tb_adder32_slice_sequencer.sv - directed vector bench for adder32_slice_sequencer
module tb_adder32_slice_sequencer;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  adder32_slice_sequencer_if #(.WIDTH(32), .SLICE(4)) bus ();

  adder32_slice_sequencer #(.WIDTH(32), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [7:0]  mask;
    logic [31:0] sum;
    logic        cout;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_start(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                             input logic [7:0] tm);
    bus.start       = 1'b1;
    bus.a           = ta;
    bus.b           = tb_v;
    bus.cin         = tc;
    bus.approx_mask = tm;
    @(negedge clk);
    bus.start       = 1'b0;
    bus.a           = 32'hDEAD_BEEF;
    bus.b           = 32'h5A5A_A5A5;
    bus.cin         = ~tc;
    bus.approx_mask = ~tm;
  endtask

  // Counts sampled cycles until done, starting from lat0, with a bounded budget
  task automatic wait_done(input int lat0, output int lat, output int busy_n, output bit overlap);
    lat     = lat0;
    busy_n  = 0;
    overlap = 1'b0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (bus.busy && bus.done) overlap = 1'b1;
  endtask

  int lat, busy_n;
  bit overlap;
  bit done_seen;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.start = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.approx_mask = '0;

    vecs[0] = '{32'h0000000F, 32'h00000001, 1'b0, 8'h00, 32'h00000010, 1'b0, 4'd0};
    vecs[1] = '{32'h0000000F, 32'h00000001, 1'b0, 8'h01, 32'h00000008, 1'b0, 4'd1};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 8'h00, 32'h00000000, 1'b1, 4'd0};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 8'hFF, 32'h88888880, 1'b1, 4'd8};
    vecs[4] = '{32'h12345678, 32'h11111111, 1'b1, 8'h00, 32'h2345678A, 1'b0, 4'd0};
    vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 8'h00, 32'h00000000, 1'b1, 4'd0};
    vecs[6] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 8'h80, 32'h00000000, 1'b0, 4'd1};
    vecs[7] = '{32'h77777777, 32'h77777777, 1'b0, 8'h0F, 32'hEEEE0000, 1'b0, 4'd4};

    @(negedge clk);
    @(negedge clk);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_sum", {32'd0, bus.sum}, 64'd0);
    check("reset_cout", {63'd0, bus.cout}, 64'd0);
    check("reset_cnt", {60'd0, bus.approx_cnt}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      drive_start(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].mask);
      wait_done(0, lat, busy_n, overlap);
      check($sformatf("v%0d_latency", i), lat, 8);
      check($sformatf("v%0d_busy_cycles", i), busy_n, 8);
      check($sformatf("v%0d_overlap", i), {63'd0, overlap}, 64'd0);
      check($sformatf("v%0d_sum", i), {32'd0, bus.sum}, {32'd0, vecs[i].sum});
      check($sformatf("v%0d_cout", i), {63'd0, bus.cout}, {63'd0, vecs[i].cout});
      check($sformatf("v%0d_cnt", i), {60'd0, bus.approx_cnt}, {60'd0, vecs[i].cnt});
      @(negedge clk);
      check($sformatf("v%0d_done_width", i), {63'd0, bus.done}, 64'd0);
      check($sformatf("v%0d_busy_after", i), {63'd0, bus.busy}, 64'd0);
      check($sformatf("v%0d_sum_held", i), {32'd0, bus.sum}, {32'd0, vecs[i].sum});
    end

    // Start during RUN is ignored; start in the DONE cycle is accepted back-to-back
    drive_start(32'h0000000F, 32'h00000001, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF; bus.approx_mask = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(3, lat, busy_n, overlap);
    check("ign_latency", lat, 8);
    check("ign_sum", {32'd0, bus.sum}, 64'h10);
    check("ign_cout", {63'd0, bus.cout}, 64'd0);
    check("ign_cnt", {60'd0, bus.approx_cnt}, 64'd0);
    drive_start(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 8'hFF);
    wait_done(0, lat, busy_n, overlap);
    check("b2b_latency", lat, 8);
    check("b2b_busy_cycles", busy_n, 8);
    check("b2b_sum", {32'd0, bus.sum}, 64'h88888880);
    check("b2b_cout", {63'd0, bus.cout}, 64'd1);
    check("b2b_cnt", {60'd0, bus.approx_cnt}, 64'd8);
    @(negedge clk);

    // Reset mid-RUN aborts with no done pulse
    drive_start(32'h11111111, 32'h11111111, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) @(negedge clk);
    check("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
    check("pre_rst_sum", {32'd0, bus.sum}, 64'h2222);
    rst_n = 1'b0;
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_sum", {32'd0, bus.sum}, 64'd0);
    check("rst_cout", {63'd0, bus.cout}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen = 1'b1;
    end
    check("rst_no_done", {63'd0, done_seen}, 64'd0);
    drive_start(32'h12345678, 32'h11111111, 1'b1, 8'h00);
    wait_done(0, lat, busy_n, overlap);
    check("post_rst_latency", lat, 8);
    check("post_rst_sum", {32'd0, bus.sum}, 64'h2345678A);
    check("post_rst_cout", {63'd0, bus.cout}, 64'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
